fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Read-side consumer for the dual-clock 8-bit FIFO, operated here with rdclk = wrclk = clk.
- Waits until the FIFO reports full, then drains it in one burst of up to BURST_LEN words.
- Checks each word against the incrementing 0..255 pattern produced by the write side, and exposes the data, an error count and burst status to downstream logic.
- Instantiated alongside the FIFO in place of the simple read controller.

Parameters:
- DW, 8, data width; must match FIFO q width.
- BURST_LEN, 256, maximum words read per burst; legal range 1..65535.
- CNT_W, 16, width of the internal burst word counter; must satisfy 2^CNT_W > BURST_LEN.

Ports:
- clk  in  1  system clock; also drives the FIFO rdclk.
- rst_n  in  1  asynchronous active-low reset.
- rdfull  in  1  FIFO read-side full flag.
- rdempty  in  1  FIFO read-side empty flag.
- q  in  DW  FIFO read data, normal (non-show-ahead) mode: valid the cycle after rdreq.
- rdreq  out  1  FIFO read request.
- dout  out  DW  last word read from the FIFO.
- dout_valid  out  1  one-cycle strobe marking dout as a new word.
- err_cnt  out  8  count of pattern mismatches, saturating at 255.
- burst_done  out  1  one-cycle strobe at the end of each burst.
- busy  out  1  high while a burst is in progress.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rdreq=0, dout=0, dout_valid=0, err_cnt=0, burst_done=0, busy=0.
  - Internal word counter=0, expected value=0, pending-read flag=0.
- States: IDLE, READ, FLUSH, DONE.
- IDLE:
  - rdreq=0, busy=0.
  - If rdfull=1 on a clock edge, go to READ, clear the word counter and set busy=1.
- READ:
  - rdreq is combinational: rdreq = (state==READ) & ~rdempty & (word_cnt < BURST_LEN). The FIFO must never be read while empty.
  - Each cycle rdreq=1, word_cnt increments.
  - Leave for FLUSH when (word_cnt == BURST_LEN) or (rdempty=1 and no read issued this cycle).
- FLUSH:
  - Exactly one cycle; captures the data for the final read issued in READ.
  - rdreq=0. Then go to DONE.
- DONE:
  - burst_done=1 for one cycle, busy=0. Return to IDLE.
- Data capture:
  - A registered pending flag equals the previous cycle's rdreq.
  - When pending=1: dout<=q, dout_valid=1 (registered, one cycle).
  - Latency: rdreq high at edge N, so q is sampled at edge N+1 and dout/dout_valid are visible after edge N+1.
- Pattern check, on each captured word:
  - If q != expected, err_cnt increments, saturating at 255.
  - In both cases, expected <= q+1 mod 2^DW. A single dropped word therefore counts as one error, not a cascade.
  - The expected value persists across bursts; only reset clears it.
- Boundaries:
  - rdempty asserting mid-burst ends the burst early (short burst), with normal FLUSH/DONE.
  - rdfull asserting while busy is ignored. A new burst starts only from IDLE.
  - BURST_LEN=1: reads exactly one word per rdfull event.
  - Expected value wraps 255 -> 0 with no error.
  - Reset asserted mid-burst: all outputs drop to reset values immediately (async); rdreq=0 in the same cycle. The next burst starts with expected=0.

Test Plan:
- Reset, then writer fills a 256-deep FIFO with 0..255; rdfull rises -> 256 rdreq cycles back-to-back, 256 dout_valid strobes with dout 0..255 in order, err_cnt=0, one burst_done, busy low afterwards.
- BURST_LEN=16, FIFO full with 0..255 -> exactly 16 reads (dout 0..15), then burst_done; the next rdfull event reads 16..31; FIFO is never read while rdempty=1.
- Full FIFO where word 0x05 is replaced by 0x07 -> err_cnt=1 at that word and resync, so the following 0x06 counts a second mismatch; final err_cnt=2.
- rdempty forced high after 10 reads -> rdreq stops the same cycle, 10 dout_valid strobes, FLUSH then burst_done, return to IDLE.
- Two consecutive full 256-word bursts with the writer's counter wrapping -> dout runs 255 -> 0 across the wrap, err_cnt=0.
- rst_n pulsed low at word 100 of a burst -> rdreq, busy and dout_valid go to 0 immediately; err_cnt=0; the next burst expects 0.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Burst consumer for the 8-bit FIFO: waits for full, drains up to BURST_LEN words and
// checks them against the writer's incrementing pattern.
module fifo_burst_reader #(
  parameter int unsigned DW        = 8,
  parameter int unsigned BURST_LEN = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdfull,
  input  logic          rdempty,
  input  logic [DW-1:0] q,
  output logic          rdreq,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic [7:0]    err_cnt,
  output logic          burst_done,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StRead, StFlush, StDone} state_e;

  localparam logic [CNT_W-1:0] BurstLen = CNT_W'(BURST_LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic             pending_q;
  logic [DW-1:0]    expected_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    rdreq      = 1'b0;
    busy       = 1'b0;
    burst_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rdfull) begin
          state_d    = StRead;
          word_cnt_d = '0;
        end
      end
      StRead: begin
        busy  = 1'b1;
        // Never read an empty FIFO, and stop once the burst quota is used up.
        rdreq = ~rdempty & (word_cnt_q < BurstLen);
        if (rdreq) begin
          word_cnt_d = word_cnt_q + CNT_W'(1);
        end
        if ((word_cnt_q == BurstLen) || (rdempty && !rdreq)) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        busy    = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        burst_done = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // q is valid the cycle after rdreq (non-show-ahead), so capture is driven by pending_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      err_cnt    <= '0;
      expected_q <= '0;
    end else begin
      pending_q  <= rdreq;
      dout_valid <= pending_q;
      if (pending_q) begin
        dout <= q;
        if ((q != expected_q) && (err_cnt != 8'hff)) begin
          err_cnt <= err_cnt + 8'd1;
        end
        // Resync on every word so a single dropped word costs one error, not a cascade.
        expected_q <= q + DW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: two instances (BURST_LEN 256 and 16) fed by a queue-based
// FIFO model, a word-level scoreboard checked every cycle, and directed burst scenarios.
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rdfull_m   [2];
  logic       rdempty_m  [2];
  logic [7:0] q_m        [2];
  logic       rdreq_m    [2];
  logic [7:0] dout_m     [2];
  logic       valid_m    [2];
  logic [7:0] err_m      [2];
  logic       done_m     [2];
  logic       busy_m     [2];

  always #5 clk = ~clk;

  fifo_burst_reader #(.DW(8), .BURST_LEN(256), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .rdfull(rdfull_m[0]), .rdempty(rdempty_m[0]), .q(q_m[0]),
    .rdreq(rdreq_m[0]), .dout(dout_m[0]), .dout_valid(valid_m[0]), .err_cnt(err_m[0]),
    .burst_done(done_m[0]), .busy(busy_m[0])
  );

  fifo_burst_reader #(.DW(8), .BURST_LEN(16), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .rdfull(rdfull_m[1]), .rdempty(rdempty_m[1]), .q(q_m[1]),
    .rdreq(rdreq_m[1]), .dout(dout_m[1]), .dout_valid(valid_m[1]), .err_cnt(err_m[1]),
    .burst_done(done_m[1]), .busy(busy_m[1])
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO contents and scoreboard state per instance.
  logic [7:0] fqa[$];
  logic [7:0] fqb[$];
  bit         pv   [2];
  logic [7:0] pw   [2];
  bit         mv   [2];
  logic [7:0] md   [2];
  logic [7:0] mexp [2];
  int         merr [2];
  int         reads      [2];
  int         last_reads [2];
  int         bursts     [2] = '{0, 0};
  int         force_after[2] = '{0, 0};

  // FIFO model: pops on sampled rdreq, flags follow occupancy after each edge.
  always @(posedge clk) begin
    int sz;
    logic [7:0] w;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        pv[k] = 1'b0;
        mv[k] = 1'b0;
        mexp[k] = 8'd0;
        merr[k] = 0;
        reads[k] = 0;
        q_m[k] <= 8'd0;
      end else begin
        mv[k] = pv[k];
        md[k] = pw[k];
        if (mv[k]) begin
          if (md[k] != mexp[k] && merr[k] < 255) merr[k]++;
          mexp[k] = md[k] + 8'd1;
        end
        if (done_m[k]) begin
          bursts[k]++;
          last_reads[k] = reads[k];
          reads[k] = 0;
        end
        pv[k] = rdreq_m[k];
        if (rdreq_m[k]) begin
          sz = (k == 0) ? fqa.size() : fqb.size();
          w = 8'd0;
          if (sz != 0) w = (k == 0) ? fqa.pop_front() : fqb.pop_front();
          pw[k] = w;
          q_m[k] <= w;
          reads[k]++;
        end
      end
      sz = (k == 0) ? fqa.size() : fqb.size();
      rdempty_m[k] <= (sz == 0) || (force_after[k] != 0 && reads[k] >= force_after[k]);
      rdfull_m[k]  <= (sz >= 256);
    end
  end

  // Scoreboard compare, every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("dout_valid[%0d]", k), valid_m[k], mv[k]);
        if (mv[k]) check($sformatf("dout[%0d]", k), dout_m[k], md[k]);
        check($sformatf("err_cnt[%0d]", k), err_m[k], merr[k]);
        check($sformatf("read_while_empty[%0d]", k), rdreq_m[k] & rdempty_m[k], 0);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    fqa.delete();
    fqb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill(input int k, input int start, input int n);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = 8'(start + i);
      if (k == 0) fqa.push_back(v);
      else fqb.push_back(v);
    end
  endtask

  task automatic wait_burst(input int k, input int budget);
    int start;
    int n;
    start = bursts[k];
    n = 0;
    while (bursts[k] == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("burst_timeout[%0d]", k), int'(bursts[k] != start), 1);
  endtask

  // Runs one burst and checks its read count, final word, error count and single done strobe.
  task automatic burst(input int k, input int exp_reads, input int exp_last, input int exp_err);
    int b0;
    b0 = bursts[k];
    wait_burst(k, 600);
    check($sformatf("burst_reads[%0d]", k), last_reads[k], exp_reads);
    check($sformatf("last_dout[%0d]", k), dout_m[k], exp_last);
    check($sformatf("final_err[%0d]", k), err_m[k], exp_err);
    check($sformatf("busy_after[%0d]", k), busy_m[k], 0);
    repeat (4) @(negedge clk);
    check($sformatf("done_count[%0d]", k), bursts[k] - b0, 1);
  endtask

  initial begin
    int n;
    // Reset values held while rst_n is low.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_rdreq[%0d]", k), rdreq_m[k], 0);
      check($sformatf("rst_busy[%0d]", k), busy_m[k], 0);
      check($sformatf("rst_dout[%0d]", k), dout_m[k], 0);
      check($sformatf("rst_valid[%0d]", k), valid_m[k], 0);
      check($sformatf("rst_err[%0d]", k), err_m[k], 0);
      check($sformatf("rst_done[%0d]", k), done_m[k], 0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full 256-word burst, then a second one across the writer's 255->0 wrap.
    fill(0, 0, 256);
    burst(0, 256, 255, 0);
    fill(0, 0, 256);
    burst(0, 256, 255, 0);

    // BURST_LEN=16: two partial drains, refilling 16 words in between.
    fill(1, 0, 256);
    burst(1, 16, 15, 0);
    fill(1, 0, 16);
    burst(1, 16, 31, 0);

    // Word 5 replaced by 7: mismatch at 7, then again at the following 6.
    do_reset();
    for (int i = 0; i < 256; i++) fqa.push_back((i == 5) ? 8'd7 : 8'(i));
    burst(0, 256, 255, 2);

    // rdempty forced after 10 reads: short burst ending on word 9.
    do_reset();
    force_after[0] = 10;
    fill(0, 0, 256);
    burst(0, 10, 9, 0);
    force_after[0] = 0;

    // Reset mid-burst at word 100; next burst must start expecting 0 again.
    do_reset();
    fill(0, 100, 256);
    n = 0;
    while (reads[0] < 100 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("reach_word_100", int'(reads[0] >= 100), 1);
    check("pre_reset_busy", busy_m[0], 1);
    rst_n = 1'b0;
    #1;
    check("async_rdreq", rdreq_m[0], 0);
    check("async_busy", busy_m[0], 0);
    check("async_valid", valid_m[0], 0);
    check("async_err", err_m[0], 0);
    fqa.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(0, 0, 256);
    burst(0, 256, 255, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
